// File: rtl/addr_arbiter.sv
// addr_arbiter: lets two burst requesters share the one registered
// address/enable port of the RAM-side delay stage.
// A burst is granted whole, then one consecutive address is issued per
// cycle with e_out high. Every burst is followed by at least one cycle
// with e_out low before the next grant can be made.
// Optional build macro ADDR_ARB_FIXED_PRIO_EN: when defined, port 0 always
// wins a tie. When undefined (the default), ties are shared round-robin.
//
// state | meaning
// IDLE  | no burst running; arbitrates unless the post-burst gap flag is set
// BURST | issuing beats 2..len+1 of the granted burst

module addr_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  pll_clock,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [LEN_WIDTH-1:0]  len0,
    output logic                  gnt0,
    output logic                  done0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [LEN_WIDTH-1:0]  len1,
    output logic                  gnt1,
    output logic                  done1,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  e_out,
    output logic                  busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state;
    logic                   gap;          // set on the last beat; forces one idle cycle
    logic                   last_served;  // port granted most recently
    logic                   owner;        // port owning the burst in flight
    logic [LEN_WIDTH-1:0]   remaining;    // beats still to issue after the current one
    logic                   win;
    logic [LEN_WIDTH-1:0]   win_len;

    // Pick the winner among the current requests
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
`ifdef ADDR_ARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = ~last_served;
`endif
        end else if (req1) begin
            win = 1'b1;
        end
        win_len = win ? len1 : len0;
    end

    // Burst FSM with all outputs registered
    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            gap         <= 1'b0;
            last_served <= 1'b1;
            owner       <= 1'b0;
            remaining   <= '0;
            addr_out    <= '0;
            e_out       <= 1'b0;
            busy        <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (gap) begin
                        // Mandatory idle cycle after a burst; requests are ignored here
                        e_out <= 1'b0;
                        busy  <= 1'b0;
                        gap   <= 1'b0;
                    end else if (req0 || req1) begin
                        owner       <= win;
                        last_served <= win;
                        gnt0        <= ~win;
                        gnt1        <= win;
                        addr_out    <= win ? addr1 : addr0;
                        e_out       <= 1'b1;
                        busy        <= 1'b1;
                        remaining   <= win_len;
                        if (win_len == '0) begin
                            done0 <= ~win;
                            done1 <= win;
                            gap   <= 1'b1;
                        end else begin
                            state <= BURST;
                        end
                    end else begin
                        e_out <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                BURST: begin
                    // Address wraps naturally at the top of the address space
                    addr_out  <= addr_out + 1'b1;
                    e_out     <= 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == LEN_WIDTH'(1)) begin
                        done0 <= ~owner;
                        done1 <= owner;
                        gap   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addr_arbiter.sv
// Directed bench for addr_arbiter: inputs change on the falling edge,
// outputs are sampled on the following falling edge.

module tb_addr_arbiter;

    logic        pll_clock = 1'b0;
    logic        reset_n   = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [10:0] addr0 = '0, addr1 = '0;
    logic [7:0]  len0 = '0, len1 = '0;
    logic        gnt0, done0, gnt1, done1, e_out, busy;
    logic [10:0] addr_out;

    int n_checks = 0;
    int n_fail   = 0;

    addr_arbiter dut (
        .pll_clock (pll_clock),
        .reset_n   (reset_n),
        .req0      (req0),
        .addr0     (addr0),
        .len0      (len0),
        .gnt0      (gnt0),
        .done0     (done0),
        .req1      (req1),
        .addr1     (addr1),
        .len1      (len1),
        .gnt1      (gnt1),
        .done1     (done1),
        .addr_out  (addr_out),
        .e_out     (e_out),
        .busy      (busy)
    );

    always #5 pll_clock = ~pll_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_gap(input string tag);
        check({tag, " gap e_out"}, e_out, 0);
        check({tag, " gap busy"},  busy,  0);
        check({tag, " gap gnt"},   {gnt1, gnt0},   0);
        check({tag, " gap done"},  {done1, done0}, 0);
    endtask

    // Request one burst on port p, then check every beat and the gap cycle.
    // Called at a falling edge while the arbiter is idle.
    task automatic burst(input string tag, input int p, input logic [10:0] base, input logic [7:0] len);
        logic [10:0] a;
        logic [1:0]  pm;
        pm = (p == 0) ? 2'b01 : 2'b10;
        if (p == 0) begin req0 = 1; addr0 = base; len0 = len; end
        else        begin req1 = 1; addr1 = base; len1 = len; end
        @(negedge pll_clock);
        check({tag, " gnt"},  {gnt1, gnt0}, pm);
        check({tag, " addr0"}, addr_out, base);
        check({tag, " e0"},   e_out, 1);
        check({tag, " busy0"}, busy, 1);
        check({tag, " done0"}, {done1, done0}, (len == 0) ? pm : 2'b00);
        req0 = 0; req1 = 0;
        for (int i = 1; i <= len; i++) begin
            @(negedge pll_clock);
            a = base + 11'(i);
            check($sformatf("%s beat%0d addr", tag, i), addr_out, a);
            check($sformatf("%s beat%0d e", tag, i), e_out, 1);
            check($sformatf("%s beat%0d gnt", tag, i), {gnt1, gnt0}, 0);
            check($sformatf("%s beat%0d done", tag, i), {done1, done0}, (i == len) ? pm : 2'b00);
        end
        @(negedge pll_clock);
        check_gap(tag);
    endtask

    task automatic do_reset();
        reset_n = 0;
        @(negedge pll_clock);
        @(negedge pll_clock);
        reset_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_order [4];
        logic [10:0] a;
`ifdef ADDR_ARB_FIXED_PRIO_EN
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        @(negedge pll_clock);
        check("reset addr", addr_out, 0);
        check("reset e", e_out, 0);
        check("reset busy", busy, 0);
        check("reset gnt/done", {gnt1, gnt0, done1, done0}, 0);
        do_reset();
        @(negedge pll_clock);
        check("idle e", e_out, 0);

        // Basic burst from port 0
        burst("t1", 0, 11'h010, 8'd3);
        // Wrap at top of address space from port 1
        burst("t3", 1, 11'h7FE, 8'd3);
        // Single-beat burst
        burst("t4", 0, 11'h123, 8'd0);

        // Tie with both requests held high
        do_reset();
        req0 = 1; addr0 = 11'h100; len0 = 0;
        req1 = 1; addr1 = 11'h200; len1 = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge pll_clock);
            check($sformatf("t2 gnt%0d", k), {gnt1, gnt0}, exp_order[k]);
            check($sformatf("t2 done%0d", k), {done1, done0}, exp_order[k]);
            check($sformatf("t2 addr%0d", k), addr_out, exp_order[k][1] ? 11'h200 : 11'h100);
            @(negedge pll_clock);
            check_gap($sformatf("t2 k%0d", k));
        end
        req0 = 0; req1 = 0;
        @(negedge pll_clock);

        // Port 1 request raised mid-burst waits for the gap
        req0 = 1; addr0 = 11'h040; len0 = 3;
        @(negedge pll_clock);
        check("t6 gnt0", {gnt1, gnt0}, 2'b01);
        req0 = 0;
        req1 = 1; addr1 = 11'h300; len1 = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge pll_clock);
            a = 11'h040 + 11'(i);
            check($sformatf("t6 beat%0d addr", i), addr_out, a);
            check($sformatf("t6 beat%0d gnt", i), {gnt1, gnt0}, 0);
        end
        addr1 = 11'h300;
        @(negedge pll_clock);
        check_gap("t6");
        @(negedge pll_clock);
        check("t6 gnt1", {gnt1, gnt0}, 2'b10);
        check("t6 addr1", addr_out, 11'h300);
        check("t6 done1", {done1, done0}, 2'b10);
        req1 = 0;
        @(negedge pll_clock);
        check_gap("t6 end");

        // Reset in the middle of an 8-beat burst
        req0 = 1; addr0 = 11'h050; len0 = 7;
        @(negedge pll_clock);
        check("t5 gnt0", gnt0, 1);
        req0 = 0;
        @(negedge pll_clock);
        @(negedge pll_clock);
        check("t5 beat2 addr", addr_out, 11'h052);
        #2 reset_n = 0;
        #1;
        check("t5 async e", e_out, 0);
        check("t5 async busy", busy, 0);
        check("t5 async addr", addr_out, 0);
        @(negedge pll_clock);
        reset_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge pll_clock);
            check($sformatf("t5 no done %0d", i), {done1, done0, e_out}, 0);
        end
        req0 = 1; addr0 = 11'h011; len0 = 0;
        req1 = 1; addr1 = 11'h022; len1 = 0;
        @(negedge pll_clock);
        check("t5 tie after reset", {gnt1, gnt0}, 2'b01);
        check("t5 tie addr", addr_out, 11'h011);
        req0 = 0; req1 = 0;
        @(negedge pll_clock);
        check_gap("t5 end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
